// File: rtl/jbi_ncio_prtq_ctl_if.sv
// Handshake and array-side bundle for the PIO return queue controller.
// master = controller view, slave = producer/consumer/array view.
interface jbi_ncio_prtq_ctl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int WIDTH      = 146
);
   logic                  enq_vld;
   logic [WIDTH-1:0]      enq_data;
   logic                  enq_rdy;
   logic                  deq_vld;
   logic [WIDTH-1:0]      deq_data;
   logic                  deq_rdy;
   logic                  prtq_csn_wr;
   logic                  prtq_csn_rd;
   logic [ADDR_WIDTH-1:0] prtq_waddr;
   logic [ADDR_WIDTH-1:0] prtq_raddr;
   logic [WIDTH-1:0]      prtq_wdata;
   logic [WIDTH-1:0]      prtq_rdata;
   logic [ADDR_WIDTH:0]   prtq_occ;
   logic                  prtq_ovf_err;

   modport master (
      input  enq_vld, enq_data, deq_rdy, prtq_rdata,
      output enq_rdy, deq_vld, deq_data, prtq_csn_wr, prtq_csn_rd,
             prtq_waddr, prtq_raddr, prtq_wdata, prtq_occ, prtq_ovf_err
   );

   modport slave (
      output enq_vld, enq_data, deq_rdy, prtq_rdata,
      input  enq_rdy, deq_vld, deq_data, prtq_csn_wr, prtq_csn_rd,
             prtq_waddr, prtq_raddr, prtq_wdata, prtq_occ, prtq_ovf_err
   );
endinterface

// File: rtl/jbi_ncio_prtq_ctl.sv
// PRTQ controller: array write/read sequencing plus a 2-entry FWFT output buffer (enq to deq_vld 3 cycles).
// Optional JBI_PRTQ_CTL_HWM_EN adds an occupancy high-water mark (hwm_clr / prtq_hwm).
module jbi_ncio_prtq_ctl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 146
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef JBI_PRTQ_CTL_HWM_EN
   input  logic                   hwm_clr,
   output logic [ADDR_WIDTH:0]    prtq_hwm,
`endif
   jbi_ncio_prtq_ctl_if.master    io
);
   // Pointers wrap naturally, so DEPTH must be 2**ADDR_WIDTH.
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   acnt_q, acnt_d, occ_q, occ_d;
   logic                  rd_pend_q, rd_pend_d, ovf_q, ovf_d;
   logic [1:0]            ocnt_q, ocnt_d;
   logic [WIDTH-1:0]      head_q, head_d, tail_q, tail_d;
   logic                  enq_rdy, enq, pop, rd;
   logic [2:0]            inflight;

   always_comb begin
      enq_rdy  = (acnt_q != FULL) & ~rst;
      enq      = io.enq_vld & enq_rdy;
      pop      = (ocnt_q != 2'd0) & io.deq_rdy;
      inflight = {1'b0, ocnt_q} + {2'b0, rd_pend_q};
      // acnt_q is pre-write, so a same-cycle write is never a read candidate.
      rd       = ~rst & (acnt_q != '0) & (inflight < (3'd2 + {2'b0, pop}));

      wptr_d    = enq ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
      rptr_d    = rd  ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
      rd_pend_d = rd;
      ovf_d     = io.enq_vld & ~enq_rdy;

      case ({enq, rd})
         2'b10:   acnt_d = acnt_q + (ADDR_WIDTH+1)'(1);
         2'b01:   acnt_d = acnt_q - (ADDR_WIDTH+1)'(1);
         default: acnt_d = acnt_q;
      endcase

      head_d = head_q;
      tail_d = tail_q;
      ocnt_d = ocnt_q;
      if (pop) begin
         head_d = tail_q;
         ocnt_d = ocnt_q - 2'd1;
      end
      // Capture lands behind whatever survives the pop.
      if (rd_pend_q) begin
         if (ocnt_d == 2'd0) head_d = io.prtq_rdata;
         else                tail_d = io.prtq_rdata;
         ocnt_d = ocnt_d + 2'd1;
      end

      occ_d = acnt_d + (ADDR_WIDTH+1)'(rd_pend_d) + (ADDR_WIDTH+1)'(ocnt_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         acnt_q    <= '0;
         rd_pend_q <= 1'b0;
         ocnt_q    <= 2'd0;
         head_q    <= '0;
         tail_q    <= '0;
         occ_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         acnt_q    <= acnt_d;
         rd_pend_q <= rd_pend_d;
         ocnt_q    <= ocnt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         occ_q     <= occ_d;
         ovf_q     <= ovf_d;
      end
   end

   assign io.enq_rdy      = enq_rdy;
   assign io.prtq_csn_wr  = ~enq;
   assign io.prtq_waddr   = wptr_q;
   assign io.prtq_wdata   = io.enq_data;
   assign io.prtq_csn_rd  = ~rd;
   assign io.prtq_raddr   = rptr_q;
   assign io.deq_vld      = (ocnt_q != 2'd0);
   assign io.deq_data     = head_q;
   assign io.prtq_occ     = occ_q;
   assign io.prtq_ovf_err = ovf_q;

`ifdef JBI_PRTQ_CTL_HWM_EN
   logic [ADDR_WIDTH:0] hwm_q, hwm_d;

   always_comb begin
      hwm_d = hwm_q;
      if (hwm_clr)             hwm_d = occ_q;
      else if (occ_q > hwm_q)  hwm_d = occ_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hwm_q <= '0;
      else     hwm_q <= hwm_d;
   end

   assign prtq_hwm = hwm_q;
`endif
endmodule

// File: tb/tb_jbi_ncio_prtq_ctl.sv
// Directed bench for jbi_ncio_prtq_ctl with a behavioural 16-entry array model.
module tb_jbi_ncio_prtq_ctl;
   localparam int AW = 4;
   localparam int W  = 146;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   jbi_ncio_prtq_ctl_if #(.ADDR_WIDTH(AW), .WIDTH(W)) io ();
`ifdef JBI_PRTQ_CTL_HWM_EN
   logic          hwm_clr;
   logic [AW:0]   prtq_hwm;
`endif

   jbi_ncio_prtq_ctl #(.ADDR_WIDTH(AW), .DEPTH(16), .WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef JBI_PRTQ_CTL_HWM_EN
      .hwm_clr  (hwm_clr),
      .prtq_hwm (prtq_hwm),
`endif
      .io       (io)
   );

   logic [W-1:0] mem [16];
   always @(posedge clk) begin
      if (!io.prtq_csn_wr) mem[io.prtq_waddr] <= io.prtq_wdata;
      if (!io.prtq_csn_rd) io.prtq_rdata <= mem[io.prtq_raddr];
   end

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      io.enq_vld  = 1'b0;
      io.enq_data = '0;
      io.deq_rdy  = 1'b0;
`ifdef JBI_PRTQ_CTL_HWM_EN
      hwm_clr = 1'b0;
`endif
      cyc;
      cyc;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      io.enq_vld  = 1'b1;
      io.enq_data = W'(16'h7777);
      io.deq_rdy  = 1'b1;
`ifdef JBI_PRTQ_CTL_HWM_EN
      hwm_clr = 1'b0;
`endif
      cyc;
      cyc;
      #4;
      total++; if (io.deq_vld !== 1'b0) begin bad++; $display("FAIL reset_deq_vld got=%0b want=0", io.deq_vld); end
      total++; if (io.enq_rdy !== 1'b0) begin bad++; $display("FAIL reset_enq_rdy got=%0b want=0", io.enq_rdy); end
      total++; if (io.prtq_csn_wr !== 1'b1) begin bad++; $display("FAIL reset_csn_wr got=%0b want=1", io.prtq_csn_wr); end
      total++; if (io.prtq_csn_rd !== 1'b1) begin bad++; $display("FAIL reset_csn_rd got=%0b want=1", io.prtq_csn_rd); end
      total++; if (io.prtq_occ !== 5'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", io.prtq_occ); end
      total++; if (io.prtq_ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", io.prtq_ovf_err); end
      total++; if (io.deq_data !== '0) begin bad++; $display("FAIL reset_deq_data got=%0h want=0", io.deq_data); end
`ifdef JBI_PRTQ_CTL_HWM_EN
      total++; if (prtq_hwm !== 5'd0) begin bad++; $display("FAIL reset_hwm got=%0d want=0", prtq_hwm); end
`endif
      cyc;
      io.enq_vld = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single;
      do_reset;
      io.enq_vld  = 1'b1;
      io.enq_data = W'(16'h1234);
      io.deq_rdy  = 1'b1;
      exp = W'(16'h1234);
      #4;
      total++; if (io.prtq_csn_wr !== 1'b0) begin bad++; $display("FAIL single_c0_csn_wr got=%0b want=0", io.prtq_csn_wr); end
      total++; if (io.prtq_waddr !== 4'd0) begin bad++; $display("FAIL single_c0_waddr got=%0d want=0", io.prtq_waddr); end
      total++; if (io.prtq_wdata !== exp) begin bad++; $display("FAIL single_c0_wdata got=%0h want=%0h", io.prtq_wdata, exp); end
      total++; if (io.prtq_csn_rd !== 1'b1) begin bad++; $display("FAIL single_c0_csn_rd got=%0b want=1", io.prtq_csn_rd); end
      cyc;
      io.enq_vld = 1'b0;
      #4;
      total++; if (io.prtq_csn_rd !== 1'b0) begin bad++; $display("FAIL single_c1_csn_rd got=%0b want=0", io.prtq_csn_rd); end
      total++; if (io.prtq_raddr !== 4'd0) begin bad++; $display("FAIL single_c1_raddr got=%0d want=0", io.prtq_raddr); end
      total++; if (io.prtq_occ !== 5'd1) begin bad++; $display("FAIL single_c1_occ got=%0d want=1", io.prtq_occ); end
      total++; if (io.deq_vld !== 1'b0) begin bad++; $display("FAIL single_c1_deq_vld got=%0b want=0", io.deq_vld); end
      cyc;
      #4;
      total++; if (io.deq_vld !== 1'b0) begin bad++; $display("FAIL single_c2_deq_vld got=%0b want=0", io.deq_vld); end
      total++; if (io.prtq_csn_rd !== 1'b1) begin bad++; $display("FAIL single_c2_csn_rd got=%0b want=1", io.prtq_csn_rd); end
      cyc;
      #4;
      total++; if (io.deq_vld !== 1'b1) begin bad++; $display("FAIL single_c3_deq_vld got=%0b want=1", io.deq_vld); end
      total++; if (io.deq_data !== exp) begin bad++; $display("FAIL single_c3_data got=%0h want=%0h", io.deq_data, exp); end
      cyc;
      #4;
      total++; if (io.deq_vld !== 1'b0) begin bad++; $display("FAIL single_c4_deq_vld got=%0b want=0", io.deq_vld); end
      total++; if (io.prtq_occ !== 5'd0) begin bad++; $display("FAIL single_c4_occ got=%0d want=0", io.prtq_occ); end
      cyc;
   endtask

   task automatic test_fill;
      int nrd;
      int got;
      nrd = 0;
      do_reset;
      io.deq_rdy = 1'b0;
      for (int i = 0; i < 18; i++) begin
         io.enq_vld  = 1'b1;
         io.enq_data = W'(256 + i);
         #4;
         total++; if (io.enq_rdy !== 1'b1) begin bad++; $display("FAIL fill_enq_rdy entry=%0d got=%0b want=1", i, io.enq_rdy); end
         if (io.prtq_csn_rd === 1'b0) begin
            total++; if (io.prtq_raddr !== AW'(nrd)) begin bad++; $display("FAIL fill_raddr got=%0d want=%0d", io.prtq_raddr, nrd); end
            nrd++;
         end
         cyc;
      end
      io.enq_vld  = 1'b1;
      io.enq_data = W'(16'hdead);
      #4;
      total++; if (io.enq_rdy !== 1'b0) begin bad++; $display("FAIL full_enq_rdy got=%0b want=0", io.enq_rdy); end
      total++; if (io.prtq_occ !== 5'd18) begin bad++; $display("FAIL full_occ got=%0d want=18", io.prtq_occ); end
      total++; if (io.prtq_csn_wr !== 1'b1) begin bad++; $display("FAIL full_csn_wr got=%0b want=1", io.prtq_csn_wr); end
      if (io.prtq_csn_rd === 1'b0) nrd++;
      total++; if (nrd !== 2) begin bad++; $display("FAIL fill_read_count got=%0d want=2", nrd); end
      cyc;
      io.enq_vld = 1'b0;
      #4;
      total++; if (io.prtq_ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%0b want=1", io.prtq_ovf_err); end
      total++; if (io.prtq_occ !== 5'd18) begin bad++; $display("FAIL ovf_occ got=%0d want=18", io.prtq_occ); end
      cyc;
      #4;
      total++; if (io.prtq_ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b want=0", io.prtq_ovf_err); end
      cyc;
      got = 0;
      io.deq_rdy = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #4;
         if (io.deq_vld === 1'b1) begin
            if (got < 18) begin
               exp = W'(256 + got);
               total++; if (io.deq_data !== exp) begin bad++; $display("FAIL fill_drain_data idx=%0d got=%0h want=%0h", got, io.deq_data, exp); end
            end
            got++;
         end
         cyc;
      end
      total++; if (got !== 18) begin bad++; $display("FAIL fill_drain_count got=%0d want=18", got); end
      io.deq_rdy = 1'b0;
   endtask

   task automatic test_stream;
      int sent, got, first_c;
      sent = 0; got = 0; first_c = -1;
      do_reset;
      io.deq_rdy = 1'b1;
      for (int c = 0; c < 200 && got < 40; c++) begin
         io.enq_vld  = (sent < 40);
         io.enq_data = W'(1000 + sent);
         #4;
         if (io.enq_vld && io.enq_rdy) sent++;
         if (first_c >= 0 && got < 40) begin
            total++; if (io.deq_vld !== 1'b1) begin bad++; $display("FAIL stream_gap cycle=%0d got=%0b want=1", c, io.deq_vld); end
         end
         if (io.deq_vld === 1'b1) begin
            if (first_c < 0) first_c = c;
            exp = W'(1000 + got);
            total++; if (io.deq_data !== exp) begin bad++; $display("FAIL stream_data idx=%0d got=%0h want=%0h", got, io.deq_data, exp); end
            got++;
         end
         cyc;
      end
      io.enq_vld = 1'b0;
      total++; if (first_c !== 3) begin bad++; $display("FAIL stream_first_cycle got=%0d want=3", first_c); end
      total++; if (got !== 40) begin bad++; $display("FAIL stream_count got=%0d want=40", got); end
   endtask

   task automatic test_back_to_back;
      int sent, got, reads, pops, extra;
      logic [3:0] pat;
      logic pop;
      sent = 0; got = 0; reads = 0; pops = 0; extra = 0;
      pat = 4'b1001;
      do_reset;
      for (int c = 0; c < 300 && got < 30; c++) begin
         io.enq_vld  = (sent < 30);
         io.enq_data = W'(3000 + sent);
         io.deq_rdy  = pat[c % 4];
         #4;
         pop = io.deq_vld & io.deq_rdy;
         if (io.prtq_csn_rd === 1'b0) begin
            total++; if ((reads - pops - int'(pop)) >= 2) begin bad++; $display("FAIL bp_read_when_full outstanding=%0d pop=%0b", reads - pops, pop); end
            reads++;
         end
         if (io.enq_vld && io.enq_rdy) sent++;
         if (pop) begin
            exp = W'(3000 + got);
            total++; if (io.deq_data !== exp) begin bad++; $display("FAIL bp_data idx=%0d got=%0h want=%0h", got, io.deq_data, exp); end
            got++;
            pops++;
         end
         cyc;
      end
      io.enq_vld = 1'b0;
      io.deq_rdy = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #4;
         if (io.deq_vld === 1'b1) extra++;
         cyc;
      end
      total++; if (got !== 30) begin bad++; $display("FAIL bp_count got=%0d want=30", got); end
      total++; if (extra !== 0) begin bad++; $display("FAIL bp_duplicate got=%0d want=0", extra); end
      io.deq_rdy = 1'b0;
   endtask

   task automatic test_reset_mid;
      do_reset;
      io.deq_rdy = 1'b0;
      for (int i = 0; i < 7; i++) begin
         io.enq_vld  = 1'b1;
         io.enq_data = W'(2000 + i);
         cyc;
      end
      io.enq_vld = 1'b0;
      #4;
      total++; if (io.prtq_occ !== 5'd7) begin bad++; $display("FAIL mid_pre_occ got=%0d want=7", io.prtq_occ); end
      cyc;
      io.enq_vld  = 1'b1;
      io.enq_data = W'(16'hbeef);
      rst = 1'b1;
      #1;
      total++; if (io.deq_vld !== 1'b0) begin bad++; $display("FAIL mid_deq_vld got=%0b want=0", io.deq_vld); end
      total++; if (io.enq_rdy !== 1'b0) begin bad++; $display("FAIL mid_enq_rdy got=%0b want=0", io.enq_rdy); end
      total++; if (io.prtq_csn_wr !== 1'b1) begin bad++; $display("FAIL mid_csn_wr got=%0b want=1", io.prtq_csn_wr); end
      total++; if (io.prtq_csn_rd !== 1'b1) begin bad++; $display("FAIL mid_csn_rd got=%0b want=1", io.prtq_csn_rd); end
      cyc;
      io.enq_vld = 1'b0;
      rst = 1'b0;
      #4;
      total++; if (io.prtq_occ !== 5'd0) begin bad++; $display("FAIL mid_post_occ got=%0d want=0", io.prtq_occ); end
      cyc;
      io.enq_vld  = 1'b1;
      io.enq_data = W'(16'h55aa);
      exp = W'(16'h55aa);
      #4;
      total++; if (io.prtq_csn_wr !== 1'b0) begin bad++; $display("FAIL mid_new_csn_wr got=%0b want=0", io.prtq_csn_wr); end
      total++; if (io.prtq_waddr !== 4'd0) begin bad++; $display("FAIL mid_new_waddr got=%0d want=0", io.prtq_waddr); end
      cyc;
      io.enq_vld = 1'b0;
      io.deq_rdy = 1'b1;
      cyc;
      cyc;
      #4;
      total++; if (io.deq_vld !== 1'b1) begin bad++; $display("FAIL mid_new_deq_vld got=%0b want=1", io.deq_vld); end
      total++; if (io.deq_data !== exp) begin bad++; $display("FAIL mid_new_data got=%0h want=%0h", io.deq_data, exp); end
      cyc;
      io.deq_rdy = 1'b0;
   endtask

`ifdef JBI_PRTQ_CTL_HWM_EN
   task automatic test_hwm;
      int pops;
      pops = 0;
      do_reset;
      io.deq_rdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         io.enq_vld  = 1'b1;
         io.enq_data = W'(4000 + i);
         cyc;
      end
      io.enq_vld = 1'b0;
      #4;
      total++; if (io.prtq_occ !== 5'd9) begin bad++; $display("FAIL hwm_occ9 got=%0d want=9", io.prtq_occ); end
      cyc;
      #4;
      total++; if (prtq_hwm !== 5'd9) begin bad++; $display("FAIL hwm_peak got=%0d want=9", prtq_hwm); end
      cyc;
      for (int c = 0; c < 50 && pops < 7; c++) begin
         io.deq_rdy = 1'b1;
         #4;
         if (io.deq_vld === 1'b1) pops++;
         cyc;
      end
      io.deq_rdy = 1'b0;
      #4;
      total++; if (io.prtq_occ !== 5'd2) begin bad++; $display("FAIL hwm_occ2 got=%0d want=2", io.prtq_occ); end
      total++; if (prtq_hwm !== 5'd9) begin bad++; $display("FAIL hwm_hold got=%0d want=9", prtq_hwm); end
      cyc;
      hwm_clr = 1'b1;
      cyc;
      hwm_clr = 1'b0;
      #4;
      total++; if (prtq_hwm !== 5'd2) begin bad++; $display("FAIL hwm_clr got=%0d want=2", prtq_hwm); end
      cyc;
   endtask
`endif

   initial begin
      io.enq_vld  = 1'b0;
      io.enq_data = '0;
      io.deq_rdy  = 1'b0;
      rst = 1'b0;
      #2;
      test_reset;
      test_single;
      test_fill;
      test_stream;
      test_back_to_back;
      test_reset_mid;
`ifdef JBI_PRTQ_CTL_HWM_EN
      test_hwm;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
